// File: rtl/mac_row_if.sv
// mac_row_if: SRAM read port and tile-row control lines of one mac_tile row
// master (mac_row_ctrl): drives mem_rd_en, mem_addr, inst_w, zero; reads mem_rd_data
// slave (SRAM + tile row): drives mem_rd_data
interface mac_row_if #(
   parameter int ADDR_BW = 11,
   parameter int DATA_BW = 32
);
   logic               mem_rd_en;
   logic [ADDR_BW-1:0] mem_addr;
   logic [DATA_BW-1:0] mem_rd_data;
   logic [1:0]         inst_w;
   logic               zero;
   modport master (output mem_rd_en, mem_addr, inst_w, zero, input mem_rd_data);
   modport slave (input mem_rd_en, mem_addr, inst_w, zero, output mem_rd_data);
endinterface

// File: rtl/mac_row_ctrl.sv
// mac_row_ctrl: west-edge sequencer for one mac_tile row (kernel load, settle, execute, drain)
// ports: clk, reset (async, active-high), start/w_base/a_base/n_act run request,
//        stall backpressure, busy/done status, bus = SRAM read port + tile-row inst_w/zero
// MAC_ROW_CTRL_ZERO_GATE_EN: when defined, zero flags all-zero activation words
module mac_row_ctrl #(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int ADDR_BW = 11,
   parameter int CNT_BW  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_BW-1:0] w_base,
   input  logic [ADDR_BW-1:0] a_base,
   input  logic [CNT_BW-1:0]  n_act,
   input  logic               stall,
   output logic               busy,
   output logic               done,
   mac_row_if.master          bus
);
   typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, EXEC, DRAIN, DONE} state_t;
   localparam logic [CNT_BW-1:0] LOAD_LAST   = CNT_BW'(ROW - 1);
   localparam logic [CNT_BW-1:0] SETTLE_LAST = CNT_BW'(COL - 1);
   localparam logic [CNT_BW-1:0] DRAIN_LAST  = CNT_BW'(ROW + COL - 1);
   state_t             state, state_nxt;
   logic [CNT_BW-1:0]  cnt, cnt_nxt, n_q;
   logic [ADDR_BW-1:0] w_q, a_q, addr_q;
   logic               w_issue, a_issue;
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      w_issue = state == LOAD_W && !stall;
      a_issue = state == EXEC && !stall;
      case (state)
         IDLE: if (start) begin
            state_nxt = LOAD_W;
            cnt_nxt = '0;
         end
         LOAD_W: if (w_issue) begin
            state_nxt = cnt == LOAD_LAST ? SETTLE : LOAD_W;
            cnt_nxt = cnt == LOAD_LAST ? '0 : cnt + 1'b1;
         end
         SETTLE: begin
            state_nxt = cnt != SETTLE_LAST ? SETTLE : n_q == '0 ? DRAIN : EXEC;
            cnt_nxt = cnt == SETTLE_LAST ? '0 : cnt + 1'b1;
         end
         EXEC: if (a_issue) begin
            state_nxt = cnt == n_q - 1'b1 ? DRAIN : EXEC;
            cnt_nxt = cnt == n_q - 1'b1 ? '0 : cnt + 1'b1;
         end
         DRAIN: begin
            state_nxt = cnt == DRAIN_LAST ? DONE : DRAIN;
            cnt_nxt = cnt == DRAIN_LAST ? '0 : cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      bus.mem_rd_en = w_issue || a_issue;
      bus.mem_addr = w_issue ? w_q + ADDR_BW'(cnt) : a_issue ? a_q + ADDR_BW'(cnt) : addr_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         n_q <= '0;
         w_q <= '0;
         a_q <= '0;
         addr_q <= '0;
         bus.inst_w <= 2'b00;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         if (state == IDLE && start) begin
            n_q <= n_act;
            w_q <= w_base;
            a_q <= a_base;
         end
         if (bus.mem_rd_en) addr_q <= bus.mem_addr;
         bus.inst_w <= {a_issue, w_issue};
      end
   end
   assign busy = state != IDLE;
   assign done = state == DONE;
`ifdef MAC_ROW_CTRL_ZERO_GATE_EN
   // SRAM data is already a registered output; gating it with the registered inst_w
   // lands the flag in the same cycle the tile sees the matching execute instruction
   assign bus.zero = bus.inst_w[1] && bus.mem_rd_data == '0;
`else
   assign bus.zero = 1'b0;
`endif
endmodule

// File: tb/tb_mac_row_ctrl.sv
// tb_mac_row_ctrl: timeline-model self-checking bench for mac_row_ctrl
module tb_mac_row_ctrl;
   localparam int ROW = 8, COL = 8, ADDR_BW = 11, CNT_BW = 8, DATA_BW = 32, MAXT = 128;
`ifdef MAC_ROW_CTRL_ZERO_GATE_EN
   localparam bit ZG = 1'b1;
`else
   localparam bit ZG = 1'b0;
`endif
   logic               clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, busy, done;
   logic [ADDR_BW-1:0] w_base = '0, a_base = '0;
   logic [CNT_BW-1:0]  n_act = '0;
   mac_row_if #(.ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW)) bus();
   mac_row_ctrl #(.ROW(ROW), .COL(COL), .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)) dut (
      .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
      .n_act(n_act), .stall(stall), .busy(busy), .done(done), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [DATA_BW-1:0] word(input logic [ADDR_BW-1:0] a);
      return a == ADDR_BW'(3) ? '0 : DATA_BW'(a) + 1;
   endfunction
   always @(posedge clk or posedge reset)
      if (reset) bus.mem_rd_data <= '0;
      else if (bus.mem_rd_en) bus.mem_rd_data <= word(bus.mem_addr);
   int total = 0, bad = 0, t = 0, e_len = 0, n_rd, n_w, n_a, done_at;
   bit active = 1'b0;
   bit e_rd[MAXT], e_busy[MAXT], e_done[MAXT], e_zero[MAXT];
   logic [1:0] e_inst[MAXT];
   logic [ADDR_BW-1:0] e_addr[MAXT];
   logic [ADDR_BW-1:0] last_addr = '0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, act, exp);
      end
   endtask
   // Expected per-cycle timeline: cycle 0 is the start cycle; reads go out in order,
   // skipping stalled cycles only while streaming, with fixed settle/drain gaps.
   task automatic build(input int n, input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] ab,
                        input int ss, input int sl);
      int tm;
      tm = 1;
      for (int i = 0; i < MAXT; i++) begin
         e_rd[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_zero[i] = 0; e_inst[i] = 2'b00; e_addr[i] = '0;
      end
      for (int k = 0; k < ROW + n; k++) begin
         if (k == ROW) tm += COL;
         while (tm >= ss && tm < ss + sl) tm++;
         e_rd[tm] = 1;
         e_addr[tm] = k < ROW ? ADDR_BW'(int'(wb) + k) : ADDR_BW'(int'(ab) + k - ROW);
         e_inst[tm + 1] = k < ROW ? 2'b01 : 2'b10;
         tm++;
      end
      if (n == 0) tm += COL;
      tm += ROW + COL;
      e_done[tm] = 1;
      for (int i = 1; i <= tm; i++) e_busy[i] = 1;
      e_len = tm + 1;
      for (int i = 0; i <= e_len; i++)
         if (!e_rd[i]) e_addr[i] = i == 0 ? last_addr : e_addr[i - 1];
      for (int i = 1; i <= e_len; i++)
         e_zero[i] = ZG && e_inst[i] == 2'b10 && word(e_addr[i - 1]) == '0;
      last_addr = e_addr[e_len];
   endtask
   always @(negedge clk) if (active) begin
      chk("rd_en", 32'(bus.mem_rd_en), 32'(e_rd[t]));
      chk("addr", 32'(bus.mem_addr), 32'(e_addr[t]));
      chk("inst_w", 32'(bus.inst_w), 32'(e_inst[t]));
      chk("zero", 32'(bus.zero), 32'(e_zero[t]));
      chk("busy", 32'(busy), 32'(e_busy[t]));
      chk("done", 32'(done), 32'(e_done[t]));
      if (bus.mem_rd_en) n_rd++;
      if (bus.inst_w == 2'b01) n_w++;
      if (bus.inst_w == 2'b10) n_a++;
      if (done) done_at = t;
   end
   task automatic run(input int n, input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] ab,
                      input int ss, input int sl, input int abort_at);
      build(n, wb, ab, ss, sl);
      @(posedge clk); #1;
      t = 0; n_rd = 0; n_w = 0; n_a = 0; done_at = -1;
      start = 1'b1; w_base = wb; a_base = ab; n_act = CNT_BW'(n); stall = 1'b0; active = 1'b1;
      while (t < e_len && !(abort_at > 0 && t == abort_at)) begin
         @(posedge clk); #1;
         t++;
         start = t == 5 || t == 6;
         w_base = ~wb; a_base = ~ab; n_act = ~CNT_BW'(n);
         stall = t >= ss && t < ss + sl;
      end
      if (abort_at == 0) begin
         @(negedge clk); #1;
         active = 1'b0; start = 1'b0; stall = 1'b0;
      end
   endtask
   task automatic chk_reset_outputs();
      chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_addr", 32'(bus.mem_addr), 0);
      chk("rst_inst_w", 32'(bus.inst_w), 0);
      chk("rst_zero", 32'(bus.zero), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
   endtask
   initial begin
      #12 chk_reset_outputs();
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk) chk("idle_busy", 32'(busy), 0);
      run(36, 11'h100, 11'h000, 0, 0, 0);
      chk("r1_done_cycle", done_at, 69);
      chk("r1_reads", n_rd, 44);
      chk("r1_inst01", n_w, 8);
      chk("r1_inst10", n_a, 36);
      chk("r1_model_addr_w0", 32'(e_addr[1]), 32'h100);
      chk("r1_model_addr_a35", 32'(e_addr[52]), 32'h023);
      run(0, 11'h100, 11'h000, 0, 0, 0);
      chk("r2_done_cycle", done_at, 33);
      chk("r2_reads", n_rd, 8);
      chk("r2_inst10", n_a, 0);
      run(36, 11'h100, 11'h000, 25, 3, 0);
      chk("r3_done_cycle", done_at, 72);
      chk("r3_reads", n_rd, 44);
      chk("r3_model_stall", 32'(e_rd[26]), 0);
      run(4, 11'h7FE, 11'h010, 0, 0, 0);
      chk("r4_model_a1", 32'(e_addr[1]), 32'h7FE);
      chk("r4_model_a2", 32'(e_addr[2]), 32'h7FF);
      chk("r4_model_a3", 32'(e_addr[3]), 32'h000);
      chk("r4_model_a8", 32'(e_addr[8]), 32'h005);
      chk("r4_done_cycle", done_at, 37);
      run(2, 11'h100, 11'h001, 10, 10, 0);
      chk("r5_done_cycle", done_at, 38);
      chk("r5_reads", n_rd, 10);
      run(36, 11'h100, 11'h000, 0, 0, 20);
      #1 active = 1'b0; reset = 1'b1; start = 1'b0;
      #1 chk_reset_outputs();
      last_addr = '0;
      repeat (2) @(negedge clk) chk("abort_no_done", 32'(done), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk) chk("abort_idle", 32'(busy), 0);
      run(36, 11'h100, 11'h000, 0, 0, 0);
      chk("r6_done_cycle", done_at, 69);
      chk("r6_reads", n_rd, 44);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mac_row_ctrl.md
# mac_row_ctrl

Sequencer driving the west edge of one row of `mac_tile` instances. On `start` it streams ROW weights from SRAM with the kernel-load instruction, idles while the kernel settles across the row, then streams `n_act` activations with the execute instruction and drains the pipeline before pulsing `done`. It sits between the activation/weight SRAM and the tile row, and owns the row's `inst_w` and `zero` control lines.

## Interface
- `ROW`, 8, weight words loaded per kernel (tiles in row)
- `COL`, 8, settle/drain depth in cycles
- `ADDR_BW`, 11, SRAM address width
- `CNT_BW`, 8, width of `n_act` and internal counters
- `DATA_BW`, 32, SRAM read data width (used only by zero gating)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `w_base`  in  ADDR_BW  first weight address; captured on accepted `start`
- `a_base`  in  ADDR_BW  first activation address; captured on accepted `start`
- `n_act`  in  CNT_BW  activation count; captured on accepted `start`
- `stall`  in  1  downstream backpressure; blocks new reads
- `mem_rd_en`  out  1  SRAM read strobe
- `mem_addr`  out  ADDR_BW  SRAM read address
- `mem_rd_data`  in  DATA_BW  SRAM data, valid one cycle after `mem_rd_en`
- `inst_w`  out  2  to tile row; [0] kernel load, [1] execute
- `zero`  out  1  to tile row; current word is all-zero
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD_W, SETTLE, EXEC, DRAIN, DONE.
- IDLE: `start`=1 captures the bases and `n_act`, clears counters, and moves to LOAD_W. `start` in any other state is ignored.
- LOAD_W: each non-stalled cycle issues a read at `w_base`+k for k=0..ROW-1. After the ROW-th issue the FSM moves to SETTLE.
- SETTLE: lasts COL cycles with no reads. The FSM then moves to EXEC, or to DRAIN if the captured `n_act`=0.
- EXEC: each non-stalled cycle issues a read at `a_base`+j for j=0..n_act-1. After the last issue the FSM moves to DRAIN.
- DRAIN: lasts ROW+COL cycles with no reads, then moves to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `stall`=1 in LOAD_W or EXEC:
  - `mem_rd_en`=0 and the counters hold.
  - A read issued in the previous cycle still completes normally.
  - `stall` has no effect in other states; SETTLE and DRAIN keep counting.
- `inst_w` is registered, with one cycle of alignment to SRAM latency:
  - `inst_w`=01 the cycle after a weight read issue.
  - `inst_w`=10 the cycle after an activation read issue.
  - `inst_w`=00 otherwise. Never 11.
- Addresses wrap modulo 2^ADDR_BW. `w_base`+ROW-1 may wrap past the top of memory.
- `mem_addr` holds its last value when `mem_rd_en`=0.

## Timing
- Reset values: state IDLE; `mem_rd_en`=0, `mem_addr`=0, `inst_w`=00, `zero`=0, `busy`=0, `done`=0; counters 0.
- Reset asserted mid-run aborts immediately. No `done` pulse is produced, and a new run requires a fresh `start`.
- Without stalls, `start` sampled at cycle 0 gives:
  - reads in cycles 1..ROW;
  - `inst_w`=01 in cycles 2..ROW+1;
  - SETTLE in cycles ROW+1..ROW+COL;
  - reads in cycles ROW+COL+1..ROW+COL+n_act;
  - `done` in cycle 2·ROW+2·COL+n_act+1.
- `busy` rises the cycle after `start` is accepted and falls in the cycle after `done`.
- `start` held high through DONE launches the next run from the IDLE cycle that follows.

## Configuration
- `MAC_ROW_CTRL_ZERO_GATE_EN` defined:
  - `zero` is registered as (`mem_rd_data`==0) during EXEC-returned data, and is valid in the same cycle as the matching `inst_w`=10.
  - `zero` is forced to 0 during weight loading.
- Undefined: `zero` is tied to 0 and `mem_rd_data` is unused.

## Test plan
- ROW=8, COL=8, `n_act`=36, `w_base`=0x100, `a_base`=0x000, no stall:
  - exactly 8 reads at 0x100..0x107, then 36 reads at 0x000..0x023;
  - `inst_w` shows 8 cycles of 01 and 36 cycles of 10;
  - `done` at cycle 69 after `start`.
- `n_act`=0: no EXEC reads and `inst_w` never 10; `done` at cycle 33.
- `stall` high for 3 cycles mid-EXEC: `mem_rd_en` low for exactly those 3 cycles, no address skipped or repeated, and `done` delayed by exactly 3 cycles.
- `w_base`=0x7FE, ROW=8: addresses 0x7FE, 0x7FF, 0x000..0x005.
- `reset` pulsed in EXEC: all outputs return to their reset values asynchronously; no `done`; a following `start` runs the full sequence cleanly.
- With `MAC_ROW_CTRL_ZERO_GATE_EN` and activation word 3 = 0: `zero`=1 only in the cycle `inst_w`=10 carries word 3.
